// File: rtl/video_capture_pkg.sv
// Shared types and helpers for the video capture monitor: FSM states, pixel type,
// default pixel/word widths and the sync-assertion edge detector.
package video_capture_pkg;

   localparam int COLOR_BITS_DEF = 1;
   localparam int PPW_DEF        = 8;
   localparam int PW             = 3 * COLOR_BITS_DEF;
   localparam int DW             = PPW_DEF * PW;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_VS,
      CAPTURE,
      FLUSH,
      DONE
   } cap_state_t;

   typedef logic [PW-1:0] pixel_t;

   // Sync is active low, so assertion is a high sample followed by a low one.
   function automatic logic sync_fall(input logic prev, input logic cur);
      return prev && !cur;
   endfunction

endpackage

// File: rtl/video_capture_if.sv
// Packed-pixel output stream, valid/ready with a frame-end marker.
// The master holds data/last stable while valid is high and ready is low.
interface video_capture_if #(
   parameter int DW = video_capture_pkg::DW
) ();
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          out_ready;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO; write visible at the read port 1 cycle later.
// Caller must not push when full unless it pops in the same cycle.
module capture_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 16
) (
   input  logic             pixel_clock,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge pixel_clock) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge pixel_clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/video_capture_monitor.sv
// Measures line/frame geometry and captures one armed frame as packed words into a FIFO.
// Word reaches the FIFO 1 cycle after its last pixel; full FIFO drops data words, LAST retries.
module video_capture_monitor
   import video_capture_pkg::*;
#(
   parameter int COLOR_BITS      = 1,
   parameter int PIXELS_PER_WORD = 8,
   parameter int FIFO_DEPTH      = 16,
   parameter int CNT_BITS        = 12
) (
   input  logic                    pixel_clock,
   input  logic                    rst_n,
   input  logic                    pix_en,
   input  logic [3*COLOR_BITS-1:0] rgb,
   input  logic                    hsync_al,
   input  logic                    vsync_al,
   input  logic                    arm,
   video_capture_if.master         stream,
   output logic [CNT_BITS-1:0]     h_total,
   output logic [CNT_BITS-1:0]     v_total,
   output logic [15:0]             frame_count,
   output logic                    busy,
   output logic                    overflow
);
   localparam int PIX_W  = 3 * COLOR_BITS;
   localparam int WORD_W = PIXELS_PER_WORD * PIX_W;
   localparam int K_W    = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [K_W-1:0]      K_LAST  = K_W'(PIXELS_PER_WORD - 1);

   logic                hs_prev, vs_prev;
   logic                hs_edge, vs_edge;
   logic [CNT_BITS-1:0] h_cnt, v_cnt;
   cap_state_t          state;
   logic [K_W-1:0]      k;
   logic [WORD_W-1:0]   word, word_next;
   logic                pend_vld, pend_last;
   logic [WORD_W-1:0]   pend_dat;
   logic                fifo_full, fifo_empty, fifo_pop, push_ok;
   logic [WORD_W:0]     fifo_rd;
   logic                active;

   assign hs_edge = pix_en && sync_fall(hs_prev, hsync_al);
   assign vs_edge = pix_en && sync_fall(vs_prev, vsync_al);
   assign active  = pix_en && hsync_al && vsync_al && (state == CAPTURE);

   always_comb begin
      word_next = word;
      word_next[int'(k)*PIX_W +: PIX_W] = rgb;
   end

   always_ff @(posedge pixel_clock) begin
      if (!rst_n) begin
         hs_prev     <= 1'b1;
         vs_prev     <= 1'b1;
         h_cnt       <= '0;
         v_cnt       <= '0;
         h_total     <= '0;
         v_total     <= '0;
         frame_count <= '0;
      end else if (pix_en) begin
         hs_prev <= hsync_al;
         vs_prev <= vsync_al;
         if (hs_edge) begin
            h_total <= (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 1'b1;
            h_cnt   <= '0;
         end else if (h_cnt != CNT_MAX) begin
            h_cnt <= h_cnt + 1'b1;
         end
         // A coincident hsync edge counts as the first line of the new frame.
         if (vs_edge) begin
            v_total     <= v_cnt;
            v_cnt       <= hs_edge ? CNT_BITS'(1) : '0;
            frame_count <= frame_count + 16'd1;
         end else if (hs_edge && v_cnt != CNT_MAX) begin
            v_cnt <= v_cnt + 1'b1;
         end
      end
   end

   assign fifo_pop = !fifo_empty && stream.out_ready;
   assign push_ok  = pend_vld && (!fifo_full || fifo_pop);

   always_ff @(posedge pixel_clock) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         k         <= '0;
         word      <= '0;
         pend_vld  <= 1'b0;
         pend_last <= 1'b0;
         pend_dat  <= '0;
      end else begin
         if (pend_vld && !push_ok) overflow <= 1'b1;
         // A refused LAST word stays pending and is offered again next cycle.
         if (push_ok || !pend_last) pend_vld <= 1'b0;

         case (state)
            IDLE, DONE: begin
               if (arm) begin
                  state    <= WAIT_VS;
                  busy     <= 1'b1;
                  overflow <= 1'b0;
               end
            end
            WAIT_VS: begin
               if (vs_edge) begin
                  state <= CAPTURE;
                  k     <= '0;
                  word  <= '0;
               end
            end
            CAPTURE: begin
               if (vs_edge) begin
                  state     <= FLUSH;
                  pend_vld  <= 1'b1;
                  pend_last <= 1'b1;
                  pend_dat  <= word;
                  word      <= '0;
                  k         <= '0;
               end else if (active) begin
                  if (k == K_LAST) begin
                     pend_vld  <= 1'b1;
                     pend_last <= 1'b0;
                     pend_dat  <= word_next;
                     word      <= '0;
                     k         <= '0;
                  end else begin
                     word <= word_next;
                     k    <= k + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (push_ok) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   capture_fifo #(
      .WIDTH (WORD_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .pixel_clock (pixel_clock),
      .rst_n       (rst_n),
      .push        (push_ok),
      .push_dat    ({pend_last, pend_dat}),
      .pop         (fifo_pop),
      .pop_dat     (fifo_rd),
      .full        (fifo_full),
      .empty       (fifo_empty)
   );

   assign stream.out_valid = !fifo_empty;
   assign stream.out_data  = fifo_rd[WORD_W-1:0];
   assign stream.out_last  = !fifo_empty && fifo_rd[WORD_W];

endmodule

// File: tb/tb_video_capture_monitor.sv
// Randomised bench for video_capture_monitor against a queue-based frame/stream model.
module tb_video_capture_monitor;
   import video_capture_pkg::*;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic        last;
      logic [23:0] dat;
   } wd_t;

   logic        clk;
   logic        rst_n;
   logic        pix_en;
   pixel_t      rgb;
   logic        hsync_al;
   logic        vsync_al;
   logic        arm;
   logic [11:0] h_total;
   logic [11:0] v_total;
   logic [15:0] frame_count;
   logic        busy;
   logic        overflow;

   video_capture_if #(.DW(24)) vif ();

   video_capture_monitor #(
      .COLOR_BITS      (1),
      .PIXELS_PER_WORD (8),
      .FIFO_DEPTH      (DEPTH),
      .CNT_BITS        (12)
   ) dut (
      .pixel_clock (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .rgb         (rgb),
      .hsync_al    (hsync_al),
      .vsync_al    (vsync_al),
      .arm         (arm),
      .stream      (vif),
      .h_total     (h_total),
      .v_total     (v_total),
      .frame_count (frame_count),
      .busy        (busy),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_cmp = 0;
   int  n_err = 0;
   bit  chk_en = 0;
   bit  rand_ready = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pixels, staged words and FIFO contents as queues.
   wd_t fifo_q[$];
   wd_t stage_q[$];
   wd_t got_q[$];
   int  pix_q[$];
   int  m_ph;   // 0 idle, 1 wait vsync, 2 capture, 3 flush, 4 done
   bit  m_hp, m_vp, m_ovf;
   int  m_hc, m_vc, m_ht, m_vt, m_fc;

   function automatic wd_t make_word(input bit last);
      wd_t w;
      int  n;
      w.last = last;
      w.dat  = '0;
      n = (pix_q.size() < 8) ? pix_q.size() : 8;
      for (int i = 0; i < n; i++) w.dat = w.dat + (24'(pix_q.pop_front()) << (3 * i));
      return w;
   endfunction

   function automatic int sat(input int v);
      return (v > 4095) ? 4095 : v;
   endfunction

   always @(posedge clk) begin
      bit  pop, hs_e, vs_e, act, pushed_last;
      int  n, ph;
      wd_t w;
      if (!rst_n) begin
         fifo_q.delete(); stage_q.delete(); pix_q.delete();
         m_ph = 0; m_hp = 1; m_vp = 1; m_ovf = 0;
         m_hc = 0; m_vc = 0; m_ht = 0; m_vt = 0; m_fc = 0;
      end else begin
         ph = m_ph;
         if (vif.out_valid && vif.out_ready) begin
            w.last = vif.out_last;
            w.dat  = vif.out_data;
            got_q.push_back(w);
         end
         n   = fifo_q.size();
         pop = (n > 0) && vif.out_ready;
         if (pop) void'(fifo_q.pop_front());
         pushed_last = 0;
         if (stage_q.size() > 0) begin
            w = stage_q.pop_front();
            if (n < DEPTH || pop) begin
               fifo_q.push_back(w);
               pushed_last = w.last;
            end else begin
               m_ovf = 1;
               if (w.last) stage_q.push_back(w);
            end
         end
         hs_e = pix_en && m_hp && !hsync_al;
         vs_e = pix_en && m_vp && !vsync_al;
         act  = pix_en && hsync_al && vsync_al && (ph == 2);
         if (pix_en) begin
            m_hp = hsync_al;
            m_vp = vsync_al;
            if (hs_e) begin m_ht = sat(m_hc + 1); m_hc = 0; end
            else m_hc = sat(m_hc + 1);
            if (vs_e) begin
               m_vt = m_vc;
               m_vc = hs_e ? 1 : 0;
               m_fc = (m_fc + 1) % 65536;
            end else if (hs_e) m_vc = sat(m_vc + 1);
         end
         case (ph)
            0, 4: if (arm) begin m_ph = 1; m_ovf = 0; end
            1: if (vs_e) m_ph = 2;
            2: begin
               if (vs_e) begin
                  stage_q.push_back(make_word(1));
                  m_ph = 3;
               end else if (act) begin
                  pix_q.push_back(int'(rgb));
                  if (pix_q.size() == 8) stage_q.push_back(make_word(0));
               end
            end
            3: if (pushed_last) m_ph = 4;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(vif.out_valid), 32'(fifo_q.size() > 0));
         if (fifo_q.size() > 0) begin
            chk("out_data", 32'(vif.out_data), 32'(fifo_q[0].dat));
            chk("out_last", 32'(vif.out_last), 32'(fifo_q[0].last));
         end else begin
            chk("out_last_idle", 32'(vif.out_last), 32'd0);
         end
         chk("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= 3));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("h_total", 32'(h_total), 32'(m_ht));
         chk("v_total", 32'(v_total), 32'(m_vt));
         chk("frame_count", 32'(frame_count), 32'(m_fc));
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rand_ready) vif.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic pulse_arm();
      tick(); arm = 1'b1; pix_en = 1'b0;
      tick(); arm = 1'b0;
   endtask

   task automatic drive_frame(input int hlen, input int hs_w, input int lines, input int vs_lines,
                              input bit idx_rgb, input bit gaps, input int arm_step);
      int aidx = 0;
      int step = 0;
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < hlen; p++) begin
            if (gaps) begin
               int g = $urandom_range(0, 2);
               for (int i = 0; i < g; i++) begin
                  tick(); pix_en = 1'b0; arm = 1'b0; rgb = pixel_t'($urandom);
               end
            end
            tick();
            pix_en   = 1'b1;
            arm      = (step == arm_step);
            hsync_al = (p >= hs_w);
            vsync_al = (l >= vs_lines);
            if (hsync_al && vsync_al) begin
               rgb = idx_rgb ? pixel_t'(aidx % 8) : pixel_t'($urandom);
               aidx++;
            end else begin
               rgb = pixel_t'($urandom);
            end
            step++;
         end
      end
      tick(); pix_en = 1'b0; arm = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      pix_en = 1'b0;
      while ((busy || vif.out_valid) && c < budget) begin
         tick();
         c++;
      end
      chk("drain_in_budget", 32'(c < budget), 32'd1);
   endtask

   initial begin
      int words;
      rst_n = 1'b0; pix_en = 1'b0; rgb = '0; hsync_al = 1'b1; vsync_al = 1'b1; arm = 1'b0;
      vif.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("rst_out_valid", 32'(vif.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_h_total", 32'(h_total), 32'd0);
      rst_n = 1'b1;

      // Geometry: 16 pixels/line, hsync 2 wide, 4 lines, vsync 1 line.
      repeat (3) drive_frame(16, 2, 4, 1, 1'b0, 1'b0, -1);
      chk("meas_h_total", 32'(h_total), 32'd16);
      chk("meas_v_total", 32'(v_total), 32'd4);
      chk("meas_frame_count", 32'(frame_count), 32'd3);

      // 42 active pixels: five full words then a LAST word holding pixels 0,1.
      got_q.delete();
      pulse_arm();
      drive_frame(16, 2, 4, 1, 1'b1, 1'b0, -1);
      drive_frame(16, 2, 2, 1, 1'b0, 1'b0, -1);
      wait_idle(200);
      chk("cap_word_count", 32'(got_q.size()), 32'd6);
      if (got_q.size() == 6) begin
         chk("cap_word0", 32'(got_q[0]), {7'd0, 1'b0, 24'hFAC688});
         chk("cap_word1", 32'(got_q[1]), {7'd0, 1'b0, 24'hFAC688});
         chk("cap_last", 32'(got_q[5]), {7'd0, 1'b1, 24'h000008});
      end
      chk("cap_busy_done", 32'(busy), 32'd0);

      // 13 active pixels: one full word, then 5 pixels with LAST.
      got_q.delete();
      pulse_arm();
      drive_frame(15, 2, 2, 1, 1'b1, 1'b0, -1);
      drive_frame(15, 2, 2, 1, 1'b0, 1'b0, -1);
      wait_idle(200);
      chk("p13_word_count", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         chk("p13_word0", 32'(got_q[0]), {7'd0, 1'b0, 24'hFAC688});
         chk("p13_last", 32'(got_q[1]), {7'd0, 1'b1, 24'h004688});
      end

      // Sink stalled: FIFO fills, fifth data word is dropped, LAST waits for room.
      got_q.delete();
      vif.out_ready = 1'b0;
      pulse_arm();
      drive_frame(16, 2, 4, 1, 1'b1, 1'b0, -1);
      drive_frame(16, 2, 2, 1, 1'b0, 1'b0, -1);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_still_busy", 32'(busy), 32'd1);
      vif.out_ready = 1'b1;
      wait_idle(200);
      chk("ovf_word_count", 32'(got_q.size()), 32'd5);
      if (got_q.size() == 5) chk("ovf_last", 32'(got_q[4]), {7'd0, 1'b1, 24'h000008});
      pulse_arm();
      chk("ovf_cleared_by_arm", 32'(overflow), 32'd0);

      // ARM pulse inside the capture must not restart it.
      got_q.delete();
      drive_frame(16, 2, 4, 1, 1'b1, 1'b0, 40);
      drive_frame(16, 2, 2, 1, 1'b0, 1'b0, -1);
      wait_idle(200);
      words = 0;
      foreach (got_q[i]) if (got_q[i].last) words++;
      chk("rearm_one_last", 32'(words), 32'd1);

      // Synchronous reset mid-capture with data waiting in the FIFO.
      vif.out_ready = 1'b0;
      pulse_arm();
      drive_frame(16, 2, 2, 1, 1'b0, 1'b0, -1);
      chk("rstmid_pre_valid", 32'(vif.out_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rstmid_out_valid", 32'(vif.out_valid), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_h_total", 32'(h_total), 32'd0);
      rst_n = 1'b1;
      vif.out_ready = 1'b1;

      // Random geometry, PIX_EN gaps and sink backpressure.
      rand_ready = 1;
      for (int f = 0; f < 6; f++) begin
         int hl = $urandom_range(10, 20);
         int hw = $urandom_range(1, 3);
         int ln = $urandom_range(3, 5);
         pulse_arm();
         drive_frame(hl, hw, ln, 1, 1'b0, 1'b1, int'($urandom_range(0, 60)));
         drive_frame(hl, hw, 2, 1, 1'b0, 1'b1, -1);
         wait_idle(2000);
      end
      rand_ready = 0;

      tick();
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
